// File: rtl/fc_sched_pkg.sv
// rtl/fc_sched_pkg.sv - shared command codes, FSM encoding and widths for the fast-control scheduler
//
// Purpose: constants and types used by fc_cmd_scheduler and rr_arbiter.
// Ports:   none (package).
package fc_sched_pkg;

  localparam int CMD_W      = 2;
  localparam int BX_W       = 12;
  localparam int OFFSET_W   = 8;
  localparam int DROP_CNT_W = 16;
  localparam int L1A_CNT_W  = 32;

  localparam logic [CMD_W-1:0] CMD_L1A          = 2'd0;
  localparam logic [CMD_W-1:0] CMD_LINK_RESET   = 2'd1;
  localparam logic [CMD_W-1:0] CMD_BUFFER_CLEAR = 2'd2;
  localparam logic [CMD_W-1:0] CMD_CALIB        = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SYNC  = 2'd1,
    ST_CALIB_WAIT = 2'd2,
    ST_RELEASE    = 2'd3
  } state_e;

  // Dropped-command counter holds at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request arbiter with registered priority pointer
//
// Purpose: picks one requester, searching from the pointer upward with wrap.
//          The pointer moves to (winner + 1) mod NUM_REQ when a grant is taken.
// Ports:
//   clk_bx, reset_n  - clock, asynchronous active-low reset (pointer -> 0)
//   grant_en_i       - a grant may be taken this cycle (pointer advances)
//   req_i            - per-requester request vector
//   grant_o          - one-hot grant (combinational)
//   grant_idx_o      - index of the granted requester
//   grant_valid_o    - at least one request is pending
//   ptr_o            - current highest-priority requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk_bx,
  input  logic               reset_n,
  input  logic               grant_en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   ptr_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    grant_o       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin : search
      int cand;
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_valid_o && req_i[IDX_W'(cand)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IDX_W'(cand);
      end
    end
    if (grant_valid_o) grant_o[grant_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en_i && grant_valid_o) begin
      ptr_d = (grant_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_bx or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fc_cmd_scheduler.sv
// rtl/fc_cmd_scheduler.sv - sequences requester commands onto the fast-control strobe outputs
//
// Purpose: grants requesters round-robin, one command at a time; aligns LINK_RESET and
//          BUFFER_CLEAR to sync_bx (with timeout), expands CALIB into calib pulse + L1A,
//          applies the L1A veto at the issue cycle, and keeps drop / L1A statistics.
// Ports:
//   clk_bx, reset_n           - bunch clock, asynchronous active-low reset
//   bx_counter, sync_bx       - current BX and the BX for aligned commands
//   calib_l1a_offset          - cycles from calib pulse to its L1A (0 treated as 1)
//   l1a_veto                  - suppresses an L1A in its issue cycle
//   req, req_cmd              - per-requester request and 2-bit command code
//   ack, ack_dropped          - one-cycle completion pulse, qualified as dropped
//   issue_*                   - one-cycle command strobes
//   busy                      - FSM not idle
//   dropped_count             - saturating count of dropped commands
//   issued_l1a_count          - wrapping count of issued L1As
module fc_cmd_scheduler
  import fc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk_bx,
  input  logic                    reset_n,
  input  logic [BX_W-1:0]         bx_counter,
  input  logic [BX_W-1:0]         sync_bx,
  input  logic [OFFSET_W-1:0]     calib_l1a_offset,
  input  logic                    l1a_veto,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [2*NUM_REQ-1:0]    req_cmd,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    ack_dropped,
  output logic                    issue_l1a,
  output logic                    issue_link_reset,
  output logic                    issue_buffer_clear,
  output logic                    issue_calib_pulse,
  output logic                    busy,
  output logic [DROP_CNT_W-1:0]   dropped_count,
  output logic [L1A_CNT_W-1:0]    issued_l1a_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT);

  state_e                 state_q, state_d;
  logic [CMD_W-1:0]       cmd_q, cmd_d;
  logic [NUM_REQ-1:0]     owner_q, owner_d;
  logic [OFFSET_W-1:0]    delay_q, delay_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   ack_dropped_q, ack_dropped_d;
  logic                   l1a_q, l1a_d;
  logic                   lr_q, lr_d;
  logic                   bc_q, bc_d;
  logic                   cal_q, cal_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [L1A_CNT_W-1:0]   l1a_cnt_q, l1a_cnt_d;

  logic                   l1a_fire;
  logic                   drop_inc;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       arb_ptr;
  logic                   arb_valid;
  logic [CMD_W-1:0]       grant_cmd;
  logic                   unused_arb_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_bx        (clk_bx),
    .reset_n       (reset_n),
    .grant_en_i    (state_q == ST_IDLE),
    .req_i         (req),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid),
    .ptr_o         (arb_ptr)
  );

  // The pointer is exported by the arbiter for observability only.
  assign unused_arb_ptr = ^arb_ptr;

  // {idx, 0} is 2*idx: the winner's command field base.
  assign grant_cmd = req_cmd[{arb_idx, 1'b0} +: CMD_W];

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    owner_d       = owner_q;
    delay_d       = delay_q;
    tmo_d         = tmo_q;
    ack_d         = '0;
    ack_dropped_d = 1'b0;
    l1a_d         = 1'b0;
    lr_d          = 1'b0;
    bc_d          = 1'b0;
    cal_d         = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    l1a_cnt_d     = l1a_cnt_q;
    l1a_fire      = 1'b0;
    drop_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_grant;
          cmd_d   = grant_cmd;
          tmo_d   = '0;
          case (grant_cmd)
            CMD_L1A: begin
              l1a_fire = 1'b1;
              state_d  = ST_RELEASE;
            end
            CMD_LINK_RESET, CMD_BUFFER_CLEAR: begin
              state_d = ST_WAIT_SYNC;
            end
            default: begin
              cal_d   = 1'b1;
              delay_d = (calib_l1a_offset == '0) ? OFFSET_W'(1) : calib_l1a_offset;
              state_d = ST_CALIB_WAIT;
            end
          endcase
        end
      end

      ST_WAIT_SYNC: begin
        // A BX match wins over a timeout landing in the same cycle.
        if (bx_counter == sync_bx) begin
          ack_d   = owner_q;
          lr_d    = (cmd_q == CMD_LINK_RESET);
          bc_d    = (cmd_q == CMD_BUFFER_CLEAR);
          state_d = ST_RELEASE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          ack_d         = owner_q;
          ack_dropped_d = 1'b1;
          drop_inc      = 1'b1;
          state_d       = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_CALIB_WAIT: begin
        if (delay_q == OFFSET_W'(1)) begin
          l1a_fire = 1'b1;
          state_d  = ST_RELEASE;
        end else begin
          delay_d = delay_q - OFFSET_W'(1);
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared L1A issue point for direct L1A and the tail of CALIB;
    // the veto is looked at only here.
    if (l1a_fire) begin
      ack_d = owner_d;
      if (l1a_veto) begin
        ack_dropped_d = 1'b1;
        drop_inc      = 1'b1;
      end else begin
        l1a_d     = 1'b1;
        l1a_cnt_d = l1a_cnt_q + L1A_CNT_W'(1);
      end
    end

    if (drop_inc) drop_cnt_d = sat_inc_drop(drop_cnt_q);
  end

  always_ff @(posedge clk_bx or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= CMD_L1A;
      owner_q       <= '0;
      delay_q       <= '0;
      tmo_q         <= '0;
      ack_q         <= '0;
      ack_dropped_q <= 1'b0;
      l1a_q         <= 1'b0;
      lr_q          <= 1'b0;
      bc_q          <= 1'b0;
      cal_q         <= 1'b0;
      drop_cnt_q    <= '0;
      l1a_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      owner_q       <= owner_d;
      delay_q       <= delay_d;
      tmo_q         <= tmo_d;
      ack_q         <= ack_d;
      ack_dropped_q <= ack_dropped_d;
      l1a_q         <= l1a_d;
      lr_q          <= lr_d;
      bc_q          <= bc_d;
      cal_q         <= cal_d;
      drop_cnt_q    <= drop_cnt_d;
      l1a_cnt_q     <= l1a_cnt_d;
    end
  end

  assign ack                = ack_q;
  assign ack_dropped        = ack_dropped_q;
  assign issue_l1a          = l1a_q;
  assign issue_link_reset   = lr_q;
  assign issue_buffer_clear = bc_q;
  assign issue_calib_pulse  = cal_q;
  assign busy               = (state_q != ST_IDLE);
  assign dropped_count      = drop_cnt_q;
  assign issued_l1a_count   = l1a_cnt_q;

endmodule

// File: tb/tb_fc_cmd_scheduler.sv
// tb/tb_fc_cmd_scheduler.sv - randomized self-checking bench for fc_cmd_scheduler
module tb_fc_cmd_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 4096;
  localparam int ORBIT   = 3564;

  logic                   clk_bx = 1'b0;
  logic                   reset_n = 1'b0;
  logic [11:0]            bx_counter = '0;
  logic [11:0]            sync_bx = '0;
  logic [7:0]             calib_l1a_offset = '0;
  logic                   l1a_veto = 1'b0;
  logic [NUM_REQ-1:0]     req = '0;
  logic [2*NUM_REQ-1:0]   req_cmd = '0;
  logic [NUM_REQ-1:0]     ack;
  logic                   ack_dropped;
  logic                   issue_l1a;
  logic                   issue_link_reset;
  logic                   issue_buffer_clear;
  logic                   issue_calib_pulse;
  logic                   busy;
  logic [15:0]            dropped_count;
  logic [31:0]            issued_l1a_count;

  fc_cmd_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_bx             (clk_bx),
    .reset_n            (reset_n),
    .bx_counter         (bx_counter),
    .sync_bx            (sync_bx),
    .calib_l1a_offset   (calib_l1a_offset),
    .l1a_veto           (l1a_veto),
    .req                (req),
    .req_cmd            (req_cmd),
    .ack                (ack),
    .ack_dropped        (ack_dropped),
    .issue_l1a          (issue_l1a),
    .issue_link_reset   (issue_link_reset),
    .issue_buffer_clear (issue_buffer_clear),
    .issue_calib_pulse  (issue_calib_pulse),
    .busy               (busy),
    .dropped_count      (dropped_count),
    .issued_l1a_count   (issued_l1a_count)
  );

  always #12 clk_bx = ~clk_bx;

  // Expected output events, keyed by the cycle in which they are visible.
  typedef struct packed {
    logic [NUM_REQ-1:0] ack;
    logic               drop;
    logic               l1a;
    logic               lr;
    logic               bc;
    logic               cal;
  } ev_t;

  ev_t         events [int];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          busy_to = -1;
  int          rr = 0;
  logic [31:0] m_l1a_cnt = '0;
  logic [15:0] m_drop_cnt = '0;
  bit          dec_valid = 0;
  int          dec_cycle = 0;
  int          dec_owner = 0;
  int          q_cmd [NUM_REQ][$];
  bit          raised [NUM_REQ];
  bit          granted [NUM_REQ];
  int          cur_cmd [NUM_REQ];
  int          veto_mode = 0;
  int          off_mode = 0;
  bit          rand_sync = 0;
  bit          scramble = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void add_ev(int at, int owner, bit drop, bit l1a, bit lr, bit bc, bit cal);
    ev_t e;
    e = events.exists(at) ? events[at] : '0;
    if (owner >= 0) e.ack[owner] = 1'b1;
    e.drop = e.drop | drop;
    e.l1a  = e.l1a | l1a;
    e.lr   = e.lr | lr;
    e.bc   = e.bc | bc;
    e.cal  = e.cal | cal;
    events[at] = e;
  endfunction

  // An L1A decided now is visible next cycle, either issued or dropped by the veto.
  function automatic void resolve_l1a(int owner, int at);
    add_ev(at, owner, l1a_veto, !l1a_veto, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic bit pending();
    for (int r = 0; r < NUM_REQ; r++)
      if (q_cmd[r].size() > 0 || raised[r]) return 1'b1;
    return 1'b0;
  endfunction

  // Transaction-level scheduling: pick a winner and lay out its whole timeline.
  function automatic void grant_model();
    int win;
    int cmd;
    int at;
    int n;
    bit drop;
    win = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win < 0 && req[(rr + k) % NUM_REQ]) win = (rr + k) % NUM_REQ;
    end
    if (win < 0) return;
    rr = (win + 1) % NUM_REQ;
    granted[win] = 1'b1;
    cmd = int'(req_cmd[2*win +: 2]);
    case (cmd)
      0: begin
        resolve_l1a(win, cyc + 1);
        busy_to = cyc + 1;
      end
      1, 2: begin
        at = cyc + TIMEOUT + 1;
        drop = 1'b1;
        for (int k = 1; k <= TIMEOUT; k++) begin
          if (drop && ((cyc + k) % ORBIT) == int'(sync_bx)) begin
            at = cyc + k + 1;
            drop = 1'b0;
          end
        end
        add_ev(at, win, drop, 1'b0, !drop && cmd == 1, !drop && cmd == 2, 1'b0);
        busy_to = at;
      end
      default: begin
        n = (calib_l1a_offset == 0) ? 1 : int'(calib_l1a_offset);
        add_ev(cyc + 1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        dec_valid = 1'b1;
        dec_cycle = cyc + n;
        dec_owner = win;
        busy_to = cyc + n + 1;
      end
    endcase
  endfunction

  task automatic step();
    ev_t e;
    @(negedge clk_bx);
    e = '0;
    if (events.exists(cyc)) begin
      e = events[cyc];
      events.delete(cyc);
    end
    if (e.l1a) m_l1a_cnt = m_l1a_cnt + 1;
    if (e.drop && m_drop_cnt != 16'hFFFF) m_drop_cnt = m_drop_cnt + 1;
    check("ack", 32'(ack), 32'(e.ack));
    check("ack_dropped", 32'(ack_dropped), 32'(e.drop));
    check("issue_l1a", 32'(issue_l1a), 32'(e.l1a));
    check("issue_link_reset", 32'(issue_link_reset), 32'(e.lr));
    check("issue_buffer_clear", 32'(issue_buffer_clear), 32'(e.bc));
    check("issue_calib_pulse", 32'(issue_calib_pulse), 32'(e.cal));
    check("busy", 32'(busy), 32'(cyc <= busy_to));
    check("dropped_count", 32'(dropped_count), 32'(m_drop_cnt));
    check("issued_l1a_count", issued_l1a_count, m_l1a_cnt);

    for (int r = 0; r < NUM_REQ; r++) begin
      if (e.ack[r]) begin
        req[r] = 1'b0;
        raised[r] = 1'b0;
        granted[r] = 1'b0;
      end else if (!raised[r] && q_cmd[r].size() > 0) begin
        cur_cmd[r] = q_cmd[r].pop_front();
        req_cmd[2*r +: 2] = 2'(cur_cmd[r]);
        req[r] = 1'b1;
        raised[r] = 1'b1;
      end else if (raised[r] && granted[r] && scramble) begin
        req_cmd[2*r +: 2] = 2'($urandom_range(0, 3));
      end
    end

    bx_counter = 12'(cyc % ORBIT);
    case (veto_mode)
      0: l1a_veto = 1'b0;
      1: l1a_veto = 1'b1;
      default: l1a_veto = ($urandom_range(0, 99) < 30);
    endcase
    if (off_mode >= 0) calib_l1a_offset = 8'(off_mode);
    else               calib_l1a_offset = 8'($urandom_range(0, 12));
    if (rand_sync && cyc > busy_to) sync_bx = 12'((cyc + int'($urandom_range(2, 40))) % ORBIT);

    if (dec_valid && dec_cycle == cyc) begin
      resolve_l1a(dec_owner, cyc + 1);
      dec_valid = 1'b0;
    end
    if (cyc > busy_to) grant_model();
    cyc++;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk_bx);
    reset_n = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ack_dropped", 32'(ack_dropped), 32'd0);
    check("rst_strobes", 32'({issue_l1a, issue_link_reset, issue_buffer_clear, issue_calib_pulse}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dropped_count", 32'(dropped_count), 32'd0);
    check("rst_issued_l1a_count", issued_l1a_count, 32'd0);
    events.delete();
    dec_valid = 1'b0;
    rr = 0;
    m_l1a_cnt = '0;
    m_drop_cnt = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (raised[r]) q_cmd[r].push_front(cur_cmd[r]);
      raised[r] = 1'b0;
      granted[r] = 1'b0;
    end
    req = '0;
    bx_counter = 12'(cyc % ORBIT);
    cyc++;
    repeat (hold - 1) begin
      @(negedge clk_bx);
      bx_counter = 12'(cyc % ORBIT);
      cyc++;
    end
    busy_to = cyc - 1;
    reset_n = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int spent;
    bit still;
    spent = 0;
    while ((pending() || cyc <= busy_to || dec_valid) && spent < budget) begin
      step();
      spent++;
    end
    still = pending() || cyc <= busy_to || dec_valid;
    if (still) check("drain_budget", 32'(still), 32'd0);
  endtask

  initial begin
    for (int r = 0; r < NUM_REQ; r++) begin
      raised[r] = 1'b0;
      granted[r] = 1'b0;
      cur_cmd[r] = 0;
    end
    do_reset(3);
    repeat (3) step();

    // Single L1A, then a vetoed L1A, then bring the pointer back to 0.
    q_cmd[0].push_back(0);
    wait_quiet(50);
    veto_mode = 1;
    q_cmd[1].push_back(0);
    wait_quiet(50);
    veto_mode = 0;
    q_cmd[3].push_back(0);
    wait_quiet(50);

    // All requesters at once, two rounds.
    for (int r = 0; r < NUM_REQ; r++) begin
      q_cmd[r].push_back(0);
      q_cmd[r].push_back(0);
    end
    wait_quiet(100);

    // LINK_RESET requested at bx 50 aligned to bx 100.
    sync_bx = 12'd100;
    while ((cyc % ORBIT) != 50) step();
    q_cmd[2].push_back(1);
    wait_quiet(200);

    // BUFFER_CLEAR to a BX beyond the orbit: times out.
    sync_bx = 12'd4000;
    q_cmd[1].push_back(2);
    wait_quiet(TIMEOUT + 100);

    // CALIB with offsets 20, 0, and 5 under veto.
    off_mode = 20;
    q_cmd[0].push_back(3);
    wait_quiet(100);
    off_mode = 0;
    q_cmd[1].push_back(3);
    wait_quiet(100);
    off_mode = 5;
    veto_mode = 1;
    q_cmd[2].push_back(3);
    wait_quiet(100);
    veto_mode = 0;

    // Reset in the middle of CALIB_WAIT; the requester re-requests afterwards.
    off_mode = 30;
    q_cmd[2].push_back(3);
    repeat (10) step();
    do_reset(2);
    off_mode = 4;
    wait_quiet(100);

    // Randomized mix.
    veto_mode = 2;
    off_mode = -1;
    rand_sync = 1'b1;
    scramble = 1'b1;
    for (int i = 0; i < 150; i++) q_cmd[$urandom_range(0, NUM_REQ - 1)].push_back(int'($urandom_range(0, 3)));
    wait_quiet(30000);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fc_cmd_scheduler.md
# fc_cmd_scheduler

Sequences fast-control commands from several independent requesters (software, calibration sequencer, run-control FSMs) onto the single fast-control command stream in the `clk_bx` domain. Grants requesters round-robin, one command at a time. Aligns link-reset and buffer-clear commands to a programmable BX within the orbit. Expands a calibration request into a calib pulse followed by an L1A at a programmed offset. Its single-cycle issue strobes drive the fast-control word bits (L1A, LINK_RESET, BUFFER_CLEAR, CALIB) ahead of the Hamming encoder.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `TIMEOUT`, 4096: WAIT_SYNC abort limit, in clk_bx cycles
- `clk_bx` in 1: 40 MHz bunch clock; the only clock
- `reset_n` in 1: asynchronous, active-low reset
- `bx_counter` in 12: current BX in orbit, from the orbit counter
- `sync_bx` in 12: BX at which LINK_RESET/BUFFER_CLEAR issue
- `calib_l1a_offset` in 8: cycles from calib pulse to its L1A
- `l1a_veto` in 1: combined busy/occupancy/deadtime veto
- `req` in NUM_REQ: per-requester request, held until ack
- `req_cmd` in 2*NUM_REQ: per-requester command code, bits [2i+1:2i]
- `ack` out NUM_REQ: one-cycle completion pulse to the granted requester
- `ack_dropped` out 1: qualifies `ack`; 1 means the command was not issued
- `issue_l1a`, `issue_link_reset`, `issue_buffer_clear`, `issue_calib_pulse` out 1 each: one-cycle strobes
- `busy` out 1: high whenever the FSM is not in IDLE
- `dropped_count` out 16: saturating count of dropped commands
- `issued_l1a_count` out 32: wrapping count of issued L1As

## Operation
- Command codes:
  - 0 = L1A
  - 1 = LINK_RESET
  - 2 = BUFFER_CLEAR
  - 3 = CALIB
- Handshake:
  - The requester holds `req` and its `req_cmd` stable until it sees `ack`, then deasserts.
  - The scheduler latches the command at grant. Later `req_cmd` changes are ignored.
  - Dropping `req` before `ack` is a protocol violation. The latched command completes regardless.
- Arbitration:
  - Happens only in IDLE.
  - Round-robin starting at (last granted + 1) mod NUM_REQ. The pointer resets to 0, so requester 0 wins first after reset.
- FSM states: IDLE, WAIT_SYNC, CALIB_WAIT, RELEASE.
- IDLE, on a grant, dispatches by command:
  - L1A: registers the strobe in the grant cycle. If `l1a_veto`=0, `issue_l1a`=1 and the L1A count increments. If `l1a_veto`=1, there is no strobe, `ack_dropped`=1 and `dropped_count` increments. Either way `ack` pulses and the next state is RELEASE.
  - LINK_RESET or BUFFER_CLEAR: go to WAIT_SYNC.
  - CALIB: pulse `issue_calib_pulse`, load delay = max(`calib_l1a_offset`, 1), go to CALIB_WAIT.
- WAIT_SYNC:
  - When `bx_counter`==`sync_bx`, pulse the matching issue strobe plus `ack`, then go to RELEASE.
  - If the timeout counter reaches TIMEOUT-1 first, give `ack` with `ack_dropped`=1, increment `dropped_count`, then go to RELEASE. This covers `sync_bx` ≥ orbit length.
- CALIB_WAIT:
  - Decrement the delay each cycle.
  - At delay==1, apply the L1A veto rule above and pulse `ack`, then go to RELEASE.
- RELEASE:
  - One idle cycle so the acked requester can drop `req`.
  - No grant is made in this state. Next state is IDLE.
- Every command issues at most one strobe of each type. Strobes are never asserted simultaneously except where the spec requires it; none does.
- `dropped_count` saturates at 0xFFFF. `issued_l1a_count` wraps.
- `l1a_veto` is sampled only in the issue cycle.

## Timing
- Reset values (async assert, sync release on `clk_bx`):
  - All outputs 0.
  - State = IDLE, RR pointer = 0, both counters = 0.
- L1A request seen in IDLE at cycle t gives `issue_l1a`+`ack` at t+1, RELEASE at t+1, IDLE at t+2.
  - Minimum spacing between back-to-back grants is 2 cycles.
- LINK_RESET/BUFFER_CLEAR: strobe and `ack` appear in the cycle after `bx_counter`==`sync_bx` is sampled in WAIT_SYNC.
- CALIB with offset N≥1: `issue_calib_pulse` at t+1, `issue_l1a` at t+1+N.
- Reset mid-command: the command is abandoned, with no `ack` and no strobe. Requesters must re-request.

## Structure
- `fc_sched_pkg` holds:
  - Command-code localparams (CMD_L1A, CMD_LINK_RESET, CMD_BUFFER_CLEAR, CMD_CALIB).
  - FSM state encoding.
  - Counter widths.
- Sub-module `rr_arbiter`: parameterised NUM_REQ, with a `grant_en` input and one-hot grant, index and pointer outputs. It is combinational plus the pointer register.
- `fc_cmd_scheduler` holds the FSM, the delay and timeout counters, and the statistics counters.

## Test plan
- Reset, then req0=L1A with veto=0: `issue_l1a` and `ack[0]` one cycle after request, `issued_l1a_count`=1, `ack_dropped`=0.
- req1=L1A with `l1a_veto`=1: no strobe, `ack[1]` with `ack_dropped`=1, `dropped_count`=1.
- All 4 requesters issue L1A simultaneously: acks in order 0,1,2,3, spaced 2 cycles apart. A second round starts at requester 0 again.
- LINK_RESET with `sync_bx`=100 requested at bx 50: `issue_link_reset`+`ack` exactly one cycle after bx 100. With `sync_bx`=4000 and orbit length 3564: dropped ack after 4096 cycles.
- CALIB with offset 20: calib strobe at t+1, L1A at t+21. With offset 0: L1A at t+2. With veto high at the L1A cycle: dropped.
- `reset_n` low during CALIB_WAIT: all outputs 0 immediately, no `ack`. After release, a new request is granted normally.
